// File: rtl/csi_2_crc_ctrl.sv
// CSI-2 long-packet CRC sequencer: feeds payload beats to an external CRC-16 engine,
// captures the trailing checksum and reports match/mismatch with a one-cycle pkt_done.
//
// state   | meaning
// IDLE    | waiting for a long-packet header
// PAYLOAD | forwarding payload beats, rem bytes still to go
// CKSUM   | waiting for the beat carrying the (rest of the) checksum
// CHECK   | compare captured checksum against the engine result
module csi_2_crc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        hdr_valid,
    input  logic [15:0] hdr_wc,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        crc_clr,
    output logic [15:0] crc_data,
    output logic        crc_data_valid,
    output logic        crc_byte_mode,
    input  logic [15:0] calc_checksum,
    output logic        busy,
    output logic [15:0] rx_checksum,
    output logic        pkt_done,
    output logic        crc_ok,
    output logic        crc_err
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CKSUM, CHECK} state_t;

    state_t      state;
    logic [15:0] rem;
    logic        odd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rem         <= 16'd0;
            odd         <= 1'b0;
            rx_checksum <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (hdr_valid) begin
                        rem   <= hdr_wc;
                        odd   <= 1'b0;
                        state <= (hdr_wc != 16'd0) ? PAYLOAD : CKSUM;
                    end
                end
                PAYLOAD: begin
                    if (data_valid) begin
                        if (rem > 16'd2) begin
                            rem <= rem - 16'd2;
                        end else begin
                            // Odd count: the spare upper byte of the last beat is the checksum LS byte
                            rem   <= 16'd0;
                            state <= CKSUM;
                            if (rem == 16'd1) begin
                                odd               <= 1'b1;
                                rx_checksum[7:0]  <= data_in[15:8];
                            end
                        end
                    end
                end
                CKSUM: begin
                    if (data_valid) begin
                        if (odd)
                            rx_checksum[15:8] <= data_in[7:0];
                        else
                            rx_checksum <= data_in;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign crc_data       = data_in;
    assign crc_clr        = !rst && (state == IDLE) && hdr_valid;
    assign crc_data_valid = !rst && (state == PAYLOAD) && data_valid;
    assign crc_byte_mode  = crc_data_valid && (rem == 16'd1);
    assign busy           = !rst && (state != IDLE);
    assign pkt_done       = !rst && (state == CHECK);
    assign crc_ok         = pkt_done && (rx_checksum == calc_checksum);
    assign crc_err        = pkt_done && (rx_checksum != calc_checksum);

endmodule

// File: tb/tb_csi_2_crc_ctrl.sv
// Bench for csi_2_crc_ctrl: drives packets from a vector table against a behavioural
// CSI-2 CRC-16 engine and checks each pkt_done against a scoreboard queue.
module tb_csi_2_crc_ctrl;

    logic        clk = 1'b0;
    logic        rst, hdr_valid, data_valid;
    logic [15:0] hdr_wc, data_in;
    logic        crc_clr, crc_data_valid, crc_byte_mode;
    logic [15:0] crc_data, calc, rx_checksum;
    logic        busy, pkt_done, crc_ok, crc_err;

    always #5 clk = ~clk;

    csi_2_crc_ctrl dut (
        .clk(clk), .rst(rst), .hdr_valid(hdr_valid), .hdr_wc(hdr_wc),
        .data_in(data_in), .data_valid(data_valid), .crc_clr(crc_clr),
        .crc_data(crc_data), .crc_data_valid(crc_data_valid),
        .crc_byte_mode(crc_byte_mode), .calc_checksum(calc), .busy(busy),
        .rx_checksum(rx_checksum), .pkt_done(pkt_done), .crc_ok(crc_ok),
        .crc_err(crc_err)
    );

    // CSI-2 CRC-16: x^16+x^12+x^5+1, LSB first, seed FFFF
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (crc_clr)
            calc <= 16'hFFFF;
        else if (crc_data_valid)
            calc <= crc_byte_mode ? crc_byte(calc, crc_data[7:0])
                                  : crc_byte(crc_byte(calc, crc_data[7:0]), crc_data[15:8]);
    end

    typedef struct packed {
        logic        ok;
        logic [15:0] rx;
        logic [15:0] calc;
        logic [16:0] beats;
        logic [16:0] bm;
    } exp_t;

    typedef struct packed {
        logic [15:0]       wc;
        logic [4:0]        nb;
        logic [13:0][15:0] beat;
        logic              stall;
        logic              exp_ok;
        logic [15:0]       exp_rx;
        logic [15:0]       exp_calc;
        logic [16:0]       exp_beats;
        logic [16:0]       exp_bm;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[6];
    int          errors = 0, checks = 0;
    int          done_cnt = 0, beat_cnt = 0, bm_cnt = 0;
    int          stray_bm = 0, bad_pass = 0;
    logic        last_clr = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sample();
        exp_t e;
        if (crc_clr) begin beat_cnt = 0; bm_cnt = 0; end
        if (crc_data_valid) begin
            beat_cnt++;
            if (crc_byte_mode) bm_cnt++;
        end
        if (crc_byte_mode && !crc_data_valid) stray_bm++;
        if (crc_data !== data_in) bad_pass++;
        last_clr = crc_clr;
        if (pkt_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_pkt_done", 32'(pkt_done), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("crc_ok", 32'(crc_ok), 32'(e.ok));
                chk("crc_err", 32'(crc_err), 32'(!e.ok));
                chk("rx_checksum", 32'(rx_checksum), 32'(e.rx));
                chk("calc_checksum", 32'(calc), 32'(e.calc));
                chk("beat_count", 32'(beat_cnt), 32'(e.beats));
                chk("byte_mode_count", 32'(bm_cnt), 32'(e.bm));
            end
        end
    endtask

    task automatic cycle(input logic r, input logic hv, input logic [15:0] wc,
                         input logic dv, input logic [15:0] d);
        rst = r; hdr_valid = hv; hdr_wc = wc; data_valid = dv; data_in = d;
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 6) begin
            cycle(1'b0, 1'b0, 16'd0, 1'b0, 16'(($urandom)));
            n++;
        end
        if (done_cnt == d0) chk("pkt_done_timeout", 32'(done_cnt), 32'(d0 + 1));
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int abort_after, input int inject_at);
        int d0;
        exp_t e;
        d0 = done_cnt;
        cycle(1'b0, 1'b1, v.wc, 1'b1, 16'hDEAD);
        chk("crc_clr_on_hdr", 32'(last_clr), 32'd1);
        for (int i = 0; i < int'(v.nb); i++) begin
            if (i == abort_after) begin
                cycle(1'b1, 1'b1, 16'h0004, 1'b1, 16'hFFFF);
                chk("busy_in_reset", 32'(busy), 32'd0);
                chk("rx_cleared_by_reset", 32'(rx_checksum), 32'd0);
                cycle(1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
                chk("busy_after_abort", 32'(busy), 32'd0);
                chk("no_done_on_abort", 32'(done_cnt), 32'(d0));
                return;
            end
            if (i == inject_at) begin
                cycle(1'b0, 1'b1, 16'h0002, 1'b0, 16'd0);
                chk("hdr_ignored_when_busy", 32'(last_clr), 32'd0);
            end
            if (v.stall) begin
                int g;
                g = $urandom_range(1, 3);
                repeat (g) cycle(1'b0, 1'b0, 16'd0, 1'b0, 16'(($urandom)));
            end
            if (i == int'(v.nb) - 1) begin
                e = '{ok: v.exp_ok, rx: v.exp_rx, calc: v.exp_calc,
                      beats: v.exp_beats, bm: v.exp_bm};
                sb.push_back(e);
            end
            cycle(1'b0, 1'b0, 16'd0, 1'b1, v.beat[i]);
        end
        wait_done(d0);
    endtask

    initial begin
        logic [15:0] spec_b[13];
        logic [15:0] r, ref_crc, d;
        logic [7:0]  lb;
        exp_t        e;
        int          d0;

        spec_b = '{16'h00FF, 16'h0000, 16'hF01E, 16'hC71E, 16'h824F, 16'hC578, 16'hE082,
                   16'h708C, 16'h3CD2, 16'hE978, 16'h00FF, 16'h0100, 16'hE569};
        r = crc_byte(crc_byte(crc_byte(16'hFFFF, 8'h01), 8'h02), 8'h03);

        for (int i = 0; i < 6; i++) vecs[i] = '0;
        vecs[0].wc = 16'd24; vecs[0].nb = 5'd13;
        for (int i = 0; i < 13; i++) vecs[0].beat[i] = spec_b[i];
        vecs[0].exp_ok = 1'b1; vecs[0].exp_rx = 16'hE569; vecs[0].exp_calc = 16'hE569;
        vecs[0].exp_beats = 17'd12;
        vecs[1] = vecs[0];
        vecs[1].beat[12] = 16'hE568; vecs[1].exp_rx = 16'hE568; vecs[1].exp_ok = 1'b0;
        vecs[2] = vecs[0];
        vecs[2].stall = 1'b1;
        vecs[3].wc = 16'd3; vecs[3].nb = 5'd3;
        vecs[3].beat[0] = 16'h0201;
        vecs[3].beat[1] = {r[7:0], 8'h03};
        vecs[3].beat[2] = {8'h00, r[15:8]};
        vecs[3].exp_ok = 1'b1; vecs[3].exp_rx = r; vecs[3].exp_calc = r;
        vecs[3].exp_beats = 17'd2; vecs[3].exp_bm = 17'd1;
        vecs[4].wc = 16'd0; vecs[4].nb = 5'd1; vecs[4].beat[0] = 16'hFFFF;
        vecs[4].exp_ok = 1'b1; vecs[4].exp_rx = 16'hFFFF; vecs[4].exp_calc = 16'hFFFF;
        vecs[5] = vecs[4];
        vecs[5].beat[0] = 16'h0000; vecs[5].exp_rx = 16'h0000; vecs[5].exp_ok = 1'b0;

        repeat (3) cycle(1'b1, 1'b1, 16'h0010, 1'b1, 16'h1234);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_crc_clr", 32'(crc_clr), 32'd0);
        chk("rst_crc_data_valid", 32'(crc_data_valid), 32'd0);
        chk("rst_byte_mode", 32'(crc_byte_mode), 32'd0);
        chk("rst_pkt_done", 32'({pkt_done, crc_ok, crc_err}), 32'd0);
        chk("rst_rx_checksum", 32'(rx_checksum), 32'd0);
        cycle(1'b0, 1'b0, 16'd0, 1'b1, 16'h5555);
        chk("idle_ignores_data", 32'({busy, crc_data_valid}), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], -1, -1);

        run_vec(vecs[0], 5, -1);
        run_vec(vecs[0], -1, -1);
        run_vec(vecs[0], -1, 3);

        // Maximum word count: 32767 full beats then one byte-mode beat
        d0 = done_cnt;
        ref_crc = 16'hFFFF;
        cycle(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'd0);
        for (int k = 0; k < 32767; k++) begin
            d = 16'(k * 7 + 3);
            ref_crc = crc_byte(crc_byte(ref_crc, d[7:0]), d[15:8]);
            cycle(1'b0, 1'b0, 16'd0, 1'b1, d);
        end
        lb = 8'h5A;
        ref_crc = crc_byte(ref_crc, lb);
        cycle(1'b0, 1'b0, 16'd0, 1'b1, {ref_crc[7:0], lb});
        e = '{ok: 1'b1, rx: ref_crc, calc: ref_crc, beats: 17'd32768, bm: 17'd1};
        sb.push_back(e);
        cycle(1'b0, 1'b0, 16'd0, 1'b1, {8'hA5, ref_crc[15:8]});
        wait_done(d0);

        chk("byte_mode_without_valid", 32'(stray_bm), 32'd0);
        chk("crc_data_passthrough", 32'(bad_pass), 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csi_2_crc_ctrl.md
CSI_2_CRC_CTRL -- requirements
Module: csi_2_crc_ctrl

Interface
REQ-001 The block SHALL have no parameters; the data path is fixed at 2 lanes (16 bits).
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- hdr_valid  in  1  one-cycle pulse: long-packet header accepted; hdr_wc valid.
- hdr_wc  in  16  payload word count, in bytes.
- data_in  in  16  lane bytes; [7:0] earlier byte, [15:8] later byte.
- data_valid  in  1  data_in holds a valid beat.
- crc_clr  out  1  CRC engine clear (seed 16'hFFFF).
- crc_data  out  16  bytes to the CRC engine.
- crc_data_valid  out  1  crc_data holds a beat to process.
- crc_byte_mode  out  1  only crc_data[7:0] is valid in this beat.
- calc_checksum  in  16  engine result; valid 1 cycle after its last valid input.
- busy  out  1  packet in progress.
- rx_checksum  out  16  captured received checksum {MS,LS}.
- pkt_done  out  1  one-cycle pulse when the check completes.
- crc_ok  out  1  with pkt_done: rx_checksum == calc_checksum.
- crc_err  out  1  with pkt_done: mismatch.

Function
REQ-003 The block SHALL implement FSM states IDLE, PAYLOAD, CKSUM and CHECK.
REQ-004 IDLE behaviour:
- hdr_valid=1 SHALL pulse crc_clr for 1 cycle.
- It SHALL load rem<=hdr_wc and set busy.
- It SHALL go to PAYLOAD if hdr_wc!=0, else to CKSUM.
- data_valid SHALL be ignored in IDLE.
REQ-005 hdr_valid SHALL be ignored in any state other than IDLE.
REQ-006 In PAYLOAD, each data_valid beat SHALL be forwarded to the engine in the same cycle, combinationally: crc_data=data_in, crc_data_valid=1.
REQ-007 In PAYLOAD, each beat with rem>2 SHALL decrement rem by 2 and stay in PAYLOAD.
REQ-008 Last-beat handling in PAYLOAD:
- rem==2: the block SHALL forward the beat with crc_byte_mode=0 and go to CKSUM.
- rem==1: the block SHALL forward the beat with crc_byte_mode=1, capture rx_checksum[7:0]<=data_in[15:8], and go to CKSUM.
REQ-009 In CKSUM, on data_valid:
- Even path: the block SHALL capture rx_checksum<={data_in[15:8],data_in[7:0]}.
- Odd path: the block SHALL capture rx_checksum[15:8]<=data_in[7:0].
- In both cases crc_data_valid SHALL be 0 and the next state SHALL be CHECK.
REQ-010 In CHECK, for exactly 1 cycle:
- pkt_done SHALL be 1.
- crc_ok SHALL be (rx_checksum==calc_checksum); crc_err SHALL be its inverse.
- The next state SHALL be IDLE and busy SHALL deassert.
REQ-011 data_valid=0 in PAYLOAD or CKSUM SHALL stall: rem, state and captures hold; crc_data_valid=0.
REQ-012 crc_data_valid SHALL be 0 in IDLE, CKSUM and CHECK; crc_byte_mode SHALL be 0 whenever crc_data_valid=0.
REQ-013 rem SHALL be 16 bits wide and SHALL never underflow; hdr_wc=16'hFFFF SHALL be supported.
REQ-014 A new hdr_valid SHALL be accepted no earlier than the cycle after pkt_done, i.e. in IDLE.
REQ-015 crc_data SHALL equal data_in at all times; consumers qualify it by crc_data_valid.

Reset
REQ-016 With rst=1 at a clock edge, the block SHALL enter IDLE and clear rem and rx_checksum to 0.
REQ-017 During reset, busy, crc_clr, crc_data_valid, crc_byte_mode, pkt_done, crc_ok and crc_err SHALL all be 0.
REQ-018 rst SHALL take priority over hdr_valid and data_valid in the same cycle.
REQ-019 Reset mid-packet SHALL abort the packet without a pkt_done pulse.
REQ-020 The first header after reset SHALL be processed normally.

Verification
REQ-021 The bench SHALL cover these directed scenarios, each checked against a real CRC engine instance:
- Spec example: hdr_wc=24; beats 00FF,0000,F01E,C71E,824F,C578,E082,708C,3CD2,E978,00FF,0100; then beat E569 -> 12 crc_data_valid beats, rx_checksum=E569, calc_checksum=E569, pkt_done with crc_ok=1.
- Corrupt checksum: same packet, checksum beat E568 -> crc_err=1, crc_ok=0.
- Stalls: same packet with data_valid=0 gaps of 1-3 cycles between beats -> identical result, crc_ok=1, no extra crc_data_valid pulses.
- Odd count: hdr_wc=3, bytes 01 02 03 plus checksum -> beat 1 full; beat 2 crc_byte_mode=1 carries 03 plus LS; beat 3 carries MS -> crc_ok against the reference model.
- Zero count: hdr_wc=0, beat FFFF -> no crc_data_valid, crc_ok=1; beat 0000 -> crc_err=1.
- Reset mid-packet: rst after 5 beats -> no pkt_done, busy=0; a following spec-example packet -> crc_ok=1. A hdr_valid while busy -> ignored, rem unchanged.
